// File: rtl/block_data_memory_pkg.sv
// rtl/block_data_memory_pkg.sv - shared widths, FSM states and op encoding for the cache<->memory link
package mem_if_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/block_data_memory_if.sv
// rtl/block_data_memory_if.sv - cache<->memory block request interface
interface block_data_memory_if;
  import mem_if_pkg::*;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_busywait;

  // dcache side
  modport master (
    output mem_read, mem_write, mem_address, mem_writedata,
    input  mem_readdata, mem_busywait
  );

  // memory side
  modport slave (
    input  mem_read, mem_write, mem_address, mem_writedata,
    output mem_readdata, mem_busywait
  );

endinterface

// File: rtl/block_ram_array.sv
// rtl/block_ram_array.sv - word array with sync write, sync clear and unregistered read
module block_ram_array
  import mem_if_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // clear wipes every word and overrides any write issued on the same edge
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < 2**AW; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  // the parent registers this value when it completes a read
  assign rdata = mem[addr];

endmodule

// File: rtl/block_data_memory.sv
// rtl/block_data_memory.sv - fixed-latency block data memory responding to dcache
module block_data_memory
  import mem_if_pkg::*;
#(
  parameter int LATENCY = 5
) (
  input  logic                clk,
  input  logic                reset,
  block_data_memory_if.slave  bus
);

  state_t            state, state_next;
  logic [CNT_W-1:0]  counter;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  op_t               op_q;
  logic [DATA_W-1:0] readdata_q;
  logic [DATA_W-1:0] ram_rdata;
  logic              req;
  logic              access_now;
  logic              ram_we;

  assign req        = bus.mem_read | bus.mem_write;
  assign access_now = (state == BUSY) && (counter == '0);
  assign ram_we     = access_now && (op_q == OP_WRITE);

  // busywait rises combinationally as soon as a request shows up in IDLE
  assign bus.mem_busywait = ((state == IDLE) && req) || (state == BUSY);
  assign bus.mem_readdata = readdata_q;

  block_ram_array #(
    .AW (ADDR_W),
    .DW (DATA_W)
  ) u_ram (
    .clk   (clk),
    .clear (reset),
    .we    (ram_we),
    .addr  (addr_q),
    .wdata (data_q),
    .rdata (ram_rdata)
  );

  // next-state: one pass IDLE -> BUSY -> DONE -> IDLE per accepted request
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = BUSY;
      BUSY:    if (counter == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // state register, request latches, latency countdown and read-data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      counter    <= '0;
      readdata_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      op_q       <= OP_READ;
    end else begin
      state <= state_next;
      if (state == IDLE && req) begin
        addr_q  <= bus.mem_address;
        data_q  <= bus.mem_writedata;
        op_q    <= bus.mem_write ? OP_WRITE : OP_READ;
        counter <= CNT_W'(LATENCY - 1);
      end else if (state == BUSY) begin
        if (counter != '0) begin
          counter <= counter - 1'b1;
        end else if (op_q == OP_READ) begin
          readdata_q <= ram_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_block_data_memory.sv
// tb/tb_block_data_memory.sv - randomized self-checking bench for block_data_memory
module tb_block_data_memory;

  localparam int LATENCY = 5;

  logic clk;
  logic reset;

  block_data_memory_if bus ();

  block_data_memory #(
    .LATENCY (LATENCY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [64];
  logic [31:0] model_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
    model_rdata = 32'h0;
  endtask

  task automatic idle_inputs();
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_address   = 6'h00;
    bus.mem_writedata = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
  endtask

  // one full transaction; optionally scrambles address/data/op once the access is in BUSY
  task automatic access(input bit rd, input bit wr, input logic [5:0] addr,
                        input logic [31:0] data, input bit disturb);
    int cnt;
    @(negedge clk);
    bus.mem_read      = rd;
    bus.mem_write     = wr;
    bus.mem_address   = addr;
    bus.mem_writedata = data;
    #1 check("busy_rise", 32'(bus.mem_busywait), 32'd1);
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (!bus.mem_busywait) break;
      cnt++;
      if (disturb && cnt == 3) begin
        bus.mem_address   = ~addr;
        bus.mem_writedata = $urandom;
        bus.mem_read      = ~rd | wr;
        bus.mem_write     = ~wr;
      end
    end
    if (wr) model_mem[addr] = data;
    else    model_rdata = model_mem[addr];
    check("busy_cycles", 32'(cnt), 32'(LATENCY + 1));
    check("readdata_done", bus.mem_readdata, model_rdata);
    idle_inputs();
    @(posedge clk);
    #1 check("idle_after_done", 32'(bus.mem_busywait), 32'd0);
    check("readdata_hold", bus.mem_readdata, model_rdata);
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    model_clear();

    do_reset();
    #1;
    check("reset_readdata", bus.mem_readdata, 32'h0);
    check("reset_busywait", 32'(bus.mem_busywait), 32'd0);

    access(1'b1, 1'b0, 6'h00, 32'h0, 1'b0);
    access(1'b0, 1'b1, 6'h05, 32'hDEADBEEF, 1'b0);
    access(1'b1, 1'b0, 6'h05, 32'h0, 1'b0);
    check("read_05", bus.mem_readdata, 32'hDEADBEEF);

    // mid-BUSY input changes must not redirect the write
    access(1'b0, 1'b1, 6'h05, 32'h0BADF00D, 1'b0);
    @(negedge clk);
    bus.mem_write = 1'b1; bus.mem_address = 6'h05; bus.mem_writedata = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus.mem_address = 6'h3F; bus.mem_writedata = 32'h11111111;
    for (int i = 0; i < 20 && bus.mem_busywait; i++) begin @(posedge clk); #1; end
    model_mem[6'h05] = 32'hCAFEF00D;
    idle_inputs();
    @(posedge clk);
    access(1'b1, 1'b0, 6'h3F, 32'h0, 1'b0);
    check("addr3f_untouched", bus.mem_readdata, 32'h0);
    access(1'b1, 1'b0, 6'h05, 32'h0, 1'b0);
    check("addr05_updated", bus.mem_readdata, 32'hCAFEF00D);

    // reset in the third BUSY cycle aborts the write
    @(negedge clk);
    bus.mem_write = 1'b1; bus.mem_address = 6'h0A; bus.mem_writedata = 32'h12345678;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #1 reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1 reset = 1'b0;
    model_clear();
    check("abort_busywait", 32'(bus.mem_busywait), 32'd0);
    check("abort_readdata", bus.mem_readdata, 32'h0);
    access(1'b1, 1'b0, 6'h0A, 32'h0, 1'b0);
    check("abort_no_commit", bus.mem_readdata, 32'h0);

    // read+write together resolves to a write
    access(1'b1, 1'b0, 6'h00, 32'h0, 1'b0);
    access(1'b1, 1'b1, 6'h10, 32'hA5A5A5A5, 1'b0);
    access(1'b1, 1'b0, 6'h10, 32'h0, 1'b0);
    check("both_is_write", bus.mem_readdata, 32'hA5A5A5A5);

    // random traffic against the array model
    for (int n = 0; n < 40; n++) begin
      logic [5:0]  a;
      logic [31:0] d;
      int          k;
      a = ($urandom % 2) ? 6'($urandom_range(0, 7)) : 6'($urandom);
      d = $urandom;
      k = $urandom % 4;
      access(k != 2, k >= 2, a, d, 1'($urandom % 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
